// File: rtl/readback_pkg.sv
// Shared types and constants for the register readback serializer.
// Define READBACK_HEADER_EN to prefix every transfer with a select header byte.
package readback_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [1:0] SEL_FLAGS   = 2'd0;
    localparam logic [1:0] SEL_DIVIDER = 2'd1;
    localparam logic [1:0] SEL_COUNT   = 2'd2;
    localparam logic [1:0] SEL_ID      = 2'd3;

    localparam logic HEADER_MSB = 1'b1;

`ifdef READBACK_HEADER_EN
    localparam int NUM_BYTES = 5;
    localparam int CNT_W     = 3;
`else
    localparam int NUM_BYTES = 4;
    localparam int CNT_W     = 2;
`endif

    localparam int SHIFT_W = NUM_BYTES * 8;

    function automatic logic [7:0] header_byte(input logic [1:0] sel);
        return {HEADER_MSB, 5'b00000, sel};
    endfunction

endpackage

// File: rtl/rb_byte_shifter.sv
// Load/shift register that presents one byte at a time, low byte first,
// with a byte counter flagging the last byte of the transfer.
module rb_byte_shifter
    import readback_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [SHIFT_W-1:0] load_word,
    output logic [7:0]         low_byte,
    output logic               last
);

    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (load) begin
            shift_q <= load_word;
            count_q <= '0;
        end else if (shift) begin
            shift_q <= shift_q >> 8;
            count_q <= count_q + 1'b1;
        end
    end

    assign low_byte = shift_q[7:0];
    assign last     = (count_q == CNT_W'(NUM_BYTES - 1));

endmodule

// File: rtl/reg_readback.sv
// Snapshots a selected 32-bit register and streams it out byte by byte over a
// valid/ready link. Optional header byte when READBACK_HEADER_EN is defined.
// Handshake: a byte moves on a rising edge where tx_valid and tx_ready are both
// high; tx_valid never drops and tx_data never changes until that happens.
module reg_readback
    import readback_pkg::*;
#(
    parameter logic [31:0] ID_WORD = 32'h534C4131
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_read,
    input  logic [1:0]  cmd_sel,
    input  logic [31:0] flags_reg,
    input  logic [31:0] divider_reg,
    input  logic [31:0] count_reg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output state_t      fsm_state
);

    state_t             state;
    state_t             state_next;
    logic [31:0]        sel_word;
    logic [SHIFT_W-1:0] load_word;
    logic               load;
    logic               shift;
    logic               last;
    logic [7:0]         low_byte;

    always_comb begin
        sel_word = ID_WORD;
        unique case (cmd_sel)
            SEL_FLAGS:   sel_word = flags_reg;
            SEL_DIVIDER: sel_word = divider_reg;
            SEL_COUNT:   sel_word = count_reg;
            SEL_ID:      sel_word = ID_WORD;
            default:     sel_word = ID_WORD;
        endcase
    end

`ifdef READBACK_HEADER_EN
    assign load_word = {sel_word, header_byte(cmd_sel)};
`else
    assign load_word = sel_word;
`endif

    assign load  = (state == IDLE) && cmd_read;
    assign shift = (state == SEND) && tx_ready;

    rb_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_word (load_word),
        .low_byte  (low_byte),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_read) state_next = SEND;
            SEND:    if (tx_ready && last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = low_byte;
                busy     = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Requests outside IDLE are dropped; remember that one was lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              overrun <= 1'b0;
        else if (cmd_read && state != IDLE)   overrun <= 1'b1;
    end

    assign fsm_state = state;

endmodule
